// File: rtl/pacman_mover.sv
// pacman_mover: grid position/direction generator for the Pac-Man sprite.
//
// Every STEP_PERIOD frame ticks (ce) the mover tries one grid step. It first
// probes the buffered joystick direction, if one is held, and otherwise the
// current heading. If a buffered turn is blocked, it falls back to the
// current heading. A blocked turn request stays buffered and is retried on
// later steps.
//
// Build option: define PACMAN_TUNNEL_EN to make the horizontal borders wrap
// (left at BORDER_X_MIN -> BORDER_X_MAX, right at BORDER_X_MAX -> BORDER_X_MIN).
// Vertical borders always block.
//
// Ports:
//   clk        - clock
//   reset_n    - synchronous active-low reset
//   ce         - frame tick, one clk wide
//   joy_valid  - joystick request strobe
//   joy_dir    - requested direction (0 up, 1 left, 2 down, 3 right)
//   map_x/y    - maze map probe address (registered)
//   map_wall   - wall flag for (map_x, map_y), valid the cycle after the address
//   xpos/ypos  - current grid cell
//   direction  - current heading
//   moving     - last step advanced the position
//   step_done  - one-cycle pulse when a step resolves
module pacman_mover #(
    parameter int unsigned BORDER_X_MIN = 1,
    parameter int unsigned BORDER_X_MAX = 28,
    parameter int unsigned BORDER_Y_MIN = 1,
    parameter int unsigned BORDER_Y_MAX = 28,
    parameter int unsigned START_X      = 2,
    parameter int unsigned START_Y      = 2,
    parameter int unsigned START_DIR    = 3,
    parameter int unsigned STEP_PERIOD  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       joy_valid,
    input  logic [1:0] joy_dir,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic       map_wall,
    output logic [4:0] xpos,
    output logic [4:0] ypos,
    output logic [1:0] direction,
    output logic       moving,
    output logic       step_done
);

    localparam int unsigned POS_W = 5;
    localparam int unsigned EXT_W = 6;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIR_W = 2;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

    localparam logic [EXT_W-1:0] X_MIN = EXT_W'(BORDER_X_MIN);
    localparam logic [EXT_W-1:0] X_MAX = EXT_W'(BORDER_X_MAX);
    localparam logic [EXT_W-1:0] Y_MIN = EXT_W'(BORDER_Y_MIN);
    localparam logic [EXT_W-1:0] Y_MAX = EXT_W'(BORDER_Y_MAX);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_A,
        S_READ_A,
        S_ADDR_B,
        S_READ_B
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   step_cnt, step_cnt_d;
    logic [DIR_W-1:0]   pend_dir, pend_dir_d;
    logic               pend_v, pend_v_d;
    logic [DIR_W-1:0]   snap_a, snap_a_d;
    logic [DIR_W-1:0]   snap_b, snap_b_d;
    logic               a_from_pend, a_from_pend_d;
    logic [POS_W-1:0]   xpos_d, ypos_d;
    logic [POS_W-1:0]   map_x_d, map_y_d;
    logic [DIR_W-1:0]   direction_d;
    logic               moving_d;
    logic               step_done_d;

    logic               trigger_c;
    logic               pend_clr_c;
    logic [DIR_W-1:0]   probe_dir_c;
    logic [EXT_W-1:0]   next_x_c, next_y_c;
    logic               in_border_c;
    logic               free_c;

    // Direction being probed: the primary candidate in the A states, the
    // current heading in the fallback states.
    assign probe_dir_c = (state == S_ADDR_B || state == S_READ_B) ? snap_b : snap_a;

    // Next cell at 6 bits so a step below 0 or above 31 is caught by the border test.
    always_comb begin
        next_x_c = {1'b0, xpos};
        next_y_c = {1'b0, ypos};
        case (probe_dir_c)
            DIR_UP:   next_y_c = {1'b0, ypos} - EXT_W'(1);
            DIR_LEFT: next_x_c = {1'b0, xpos} - EXT_W'(1);
            DIR_DOWN: next_y_c = {1'b0, ypos} + EXT_W'(1);
            default:  next_x_c = {1'b0, xpos} + EXT_W'(1);
        endcase
`ifdef PACMAN_TUNNEL_EN
        if (probe_dir_c == DIR_LEFT && {1'b0, xpos} == X_MIN) begin
            next_x_c = X_MAX;
        end
        if (probe_dir_c == DIR_RIGHT && {1'b0, xpos} == X_MAX) begin
            next_x_c = X_MIN;
        end
`endif
        in_border_c = (next_x_c >= X_MIN) && (next_x_c <= X_MAX) &&
                      (next_y_c >= Y_MIN) && (next_y_c <= Y_MAX);
    end

    assign free_c    = in_border_c && !map_wall;
    assign trigger_c = ce && (step_cnt == STEP_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        step_cnt_d    = step_cnt;
        pend_dir_d    = pend_dir;
        pend_v_d      = pend_v;
        snap_a_d      = snap_a;
        snap_b_d      = snap_b;
        // A newer joystick request replaces the snapshotted one, so it must
        // not be cleared when the older request commits.
        a_from_pend_d = a_from_pend && !joy_valid;
        xpos_d        = xpos;
        ypos_d        = ypos;
        direction_d   = direction;
        moving_d      = moving;
        map_x_d       = map_x;
        map_y_d       = map_y;
        step_done_d   = 1'b0;
        pend_clr_c    = 1'b0;

        // Free-running step counter; a trigger outside IDLE is simply lost.
        if (ce) begin
            step_cnt_d = trigger_c ? '0 : step_cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (trigger_c) begin
                    snap_a_d      = pend_v ? pend_dir : direction;
                    snap_b_d      = direction;
                    a_from_pend_d = pend_v && !joy_valid;
                    state_d       = S_ADDR_A;
                end
            end
            S_ADDR_A: begin
                map_x_d = next_x_c[POS_W-1:0];
                map_y_d = next_y_c[POS_W-1:0];
                state_d = S_READ_A;
            end
            S_READ_A: begin
                if (free_c) begin
                    xpos_d      = next_x_c[POS_W-1:0];
                    ypos_d      = next_y_c[POS_W-1:0];
                    direction_d = snap_a;
                    moving_d    = 1'b1;
                    pend_clr_c  = a_from_pend;
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (snap_a == snap_b) begin
                    moving_d    = 1'b0;
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_ADDR_B;
                end
            end
            S_ADDR_B: begin
                map_x_d = next_x_c[POS_W-1:0];
                map_y_d = next_y_c[POS_W-1:0];
                state_d = S_READ_B;
            end
            S_READ_B: begin
                if (free_c) begin
                    xpos_d      = next_x_c[POS_W-1:0];
                    ypos_d      = next_y_c[POS_W-1:0];
                    direction_d = snap_b;
                    moving_d    = 1'b1;
                end else begin
                    moving_d    = 1'b0;
                end
                step_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Joystick beats a same-cycle clear: the newest request always survives.
        if (joy_valid) begin
            pend_v_d   = 1'b1;
            pend_dir_d = joy_dir;
        end else if (pend_clr_c) begin
            pend_v_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            step_cnt    <= '0;
            pend_dir    <= '0;
            pend_v      <= 1'b0;
            snap_a      <= '0;
            snap_b      <= '0;
            a_from_pend <= 1'b0;
            xpos        <= POS_W'(START_X);
            ypos        <= POS_W'(START_Y);
            direction   <= DIR_W'(START_DIR);
            moving      <= 1'b0;
            step_done   <= 1'b0;
            map_x       <= '0;
            map_y       <= '0;
        end else begin
            state       <= state_d;
            step_cnt    <= step_cnt_d;
            pend_dir    <= pend_dir_d;
            pend_v      <= pend_v_d;
            snap_a      <= snap_a_d;
            snap_b      <= snap_b_d;
            a_from_pend <= a_from_pend_d;
            xpos        <= xpos_d;
            ypos        <= ypos_d;
            direction   <= direction_d;
            moving      <= moving_d;
            step_done   <= step_done_d;
            map_x       <= map_x_d;
            map_y       <= map_y_d;
        end
    end

endmodule

// File: tb/tb_pacman_mover.sv
// Testbench for pacman_mover: directed scenarios followed by random joystick,
// ce and maze traffic. Each step trigger pushes the expected outcome into a
// queue; a negedge monitor pops it when step_done appears and compares.
module tb_pacman_mover;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       joy_valid;
    logic [1:0] joy_dir;
    logic [4:0] map_x, map_y, xpos, ypos;
    logic       map_wall;
    logic [1:0] direction;
    logic       moving, step_done;

    logic wall [0:31][0:31];
    assign map_wall = wall[map_x][map_y];

    always #5 clk = ~clk;

    pacman_mover dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .joy_valid (joy_valid),
        .joy_dir   (joy_dir),
        .map_x     (map_x),
        .map_y     (map_y),
        .map_wall  (map_wall),
        .xpos      (xpos),
        .ypos      (ypos),
        .direction (direction),
        .moving    (moving),
        .step_done (step_done)
    );

    typedef struct {
        int x, y, d, mv, px, py, cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state.
    int mx, my, md, mpv, mpd, mcnt;
    bit trig;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Target cell for a move from (x,y) heading d, and whether it can be entered.
    function automatic void probe(input int x, input int y, input int d,
                                  output int nx, output int ny, output bit free);
        nx = x;
        ny = y;
        case (d)
            0: ny = y - 1;
            1: nx = x - 1;
            2: ny = y + 1;
            default: nx = x + 1;
        endcase
`ifdef PACMAN_TUNNEL_EN
        if (d == 1 && x == 1)  nx = 28;
        if (d == 3 && x == 28) nx = 1;
`endif
        free = (nx >= 1 && nx <= 28 && ny >= 1 && ny <= 28) && !wall[nx & 31][ny & 31];
    endfunction

    task automatic model_reset();
        mx = 2; my = 2; md = 3; mpv = 0; mpd = 0; mcnt = 0;
        q.delete();
    endtask

    // One clock: drive inputs, advance the model across the coming edge.
    task automatic cycle_in(input bit c, input bit jv, input int jd);
        exp_t e;
        int   a, nx, ny;
        bit   fr;
        ce        = c;
        joy_valid = jv;
        joy_dir   = 2'(jd);
        trig      = 0;
        if (c) begin
            mcnt++;
            if (mcnt == P) begin
                mcnt = 0;
                trig = 1;
                a = mpv ? mpd : md;
                probe(mx, my, a, nx, ny, fr);
                e.px = nx & 31;
                e.py = ny & 31;
                if (fr) begin
                    mx = nx; my = ny; md = a; e.mv = 1; e.cyc = cyc + 3;
                    if (mpv != 0) mpv = 0;
                end else if (a == md) begin
                    e.mv = 0; e.cyc = cyc + 3;
                end else begin
                    probe(mx, my, md, nx, ny, fr);
                    e.px = nx & 31;
                    e.py = ny & 31;
                    e.cyc = cyc + 5;
                    if (fr) begin
                        mx = nx; my = ny; e.mv = 1;
                    end else begin
                        e.mv = 0;
                    end
                end
                e.x = mx; e.y = my; e.d = md;
                q.push_back(e);
            end
        end
        if (jv) begin
            mpv = 1;
            mpd = jd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_in(0, 0, 0);
    endtask

    task automatic run_to_trigger();
        for (int i = 0; i < 2 * P; i++) begin
            cycle_in(1, 0, 0);
            if (trig) break;
        end
    endtask

    task automatic run_step();
        run_to_trigger();
        idle(6);
    endtask

    task automatic do_reset();
        reset_n = 0;
        ce = 0; joy_valid = 0; joy_dir = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_xpos", xpos, 2);
        check("rst_ypos", ypos, 2);
        check("rst_dir", direction, 3);
        check("rst_moving", moving, 0);
        check("rst_step_done", step_done, 0);
        check("rst_map_x", map_x, 0);
        check("rst_map_y", map_y, 0);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                wall[i][j] = 1'b0;
    endtask

    task automatic random_map();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                wall[i][j] = ($urandom_range(0, 3) == 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (step_done) begin
            check("step_done_expected", q.size(), 1 + (q.size() > 1 ? q.size() - 1 : 0));
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("xpos", xpos, e.x);
                check("ypos", ypos, e.y);
                check("direction", direction, e.d);
                check("moving", moving, e.mv);
                check("map_x", map_x, e.px);
                check("map_y", map_y, e.py);
                check("latency", cyc, e.cyc);
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            check("step_timeout", cyc, q[0].cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        bit remapped;
        ce = 0; joy_valid = 0; joy_dir = 0; reset_n = 0;
        clear_map();
        @(posedge clk);
        #1;
        do_reset();

        // Open map: first step moves right to (3,2).
        run_step();

        // Buffered turn down blocked at (3,3): fallback right, turn taken next step.
        cycle_in(0, 1, 2);
        wall[3][3] = 1'b1;
        run_step();
        wall[3][3] = 1'b0;
        run_step();

        // Dead end heading right.
        cycle_in(0, 1, 3);
        run_step();
        wall[6][3] = 1'b1;
        run_step();
        wall[6][3] = 1'b0;

        // March to the right border, then step into it.
        for (int i = 0; i < 23; i++) run_step();
        check("at_border_x", xpos, 28);
        run_step();

        // Late request at E1 applies only to the following step.
        run_to_trigger();
        cycle_in(0, 1, 0);
        idle(5);
        run_step();

        // Reset one cycle after the trigger aborts the probe.
        run_to_trigger();
        q.delete();
        do_reset();
        idle(8);

        // Random traffic over random mazes.
        remapped = 0;
        for (int i = 0; i < 2000; i++) begin
            if (mcnt == 5 && !remapped) begin
                if ($urandom_range(0, 4) == 0) clear_map();
                else random_map();
                remapped = 1;
            end
            cycle_in($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 3)));
            if (trig) remapped = 0;
        end
        idle(10);
        check("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pacman_mover.md
# pacman_mover

Position/direction generator for the Pac-Man sprite. Turns joystick requests into grid moves, probes the maze map for walls, and drives the `xpos`/`ypos`/`direction` bus that the sprite renderer consumes. Steps once every `STEP_PERIOD` frame ticks (`ce`), with one-deep turn buffering: a blocked turn request is held and retried on later steps.

## Interface

**Parameters**
- `BORDER_X_MIN`, default 1: lowest legal grid column.
- `BORDER_X_MAX`, default 28: highest legal grid column.
- `BORDER_Y_MIN`, default 1: lowest legal grid row.
- `BORDER_Y_MAX`, default 28: highest legal grid row.
- `START_X`, default 2: column after reset.
- `START_Y`, default 2: row after reset.
- `START_DIR`, default 3: direction after reset.
- `STEP_PERIOD`, default 8: `ce` ticks per step; range 1..255.

**Ports**
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ce` in 1: frame tick, one `clk` wide.
- `joy_valid` in 1: joystick request strobe.
- `joy_dir` in 2: requested direction.
- `map_x` out 5: map probe column.
- `map_y` out 5: map probe row.
- `map_wall` in 1: wall flag for the cell at (`map_x`, `map_y`); valid one cycle after the address changes.
- `xpos` out 5: current column.
- `ypos` out 5: current row.
- `direction` out 2: current heading.
- `moving` out 1: last step advanced the position.
- `step_done` out 1: one-cycle pulse when a step resolves.

## Operation

**Direction encoding**
- 0 = up (y−1), 1 = left (x−1), 2 = down (y+1), 3 = right (x+1).

**Pending request (`pend_dir`/`pend_v`)**
- `joy_valid` loads `pend_dir` and sets `pend_v`. The last request wins.
- `pend_v` clears only when the pending direction commits.

**Step counter**
- 8-bit counter, incremented on `ce`.
- On `ce` with count == `STEP_PERIOD`−1: counter goes to 0 and a step triggers.
- A trigger arriving while the FSM is not IDLE is dropped; the counter still wraps.

**FSM**
- IDLE: on trigger, snapshot A = (`pend_v` ? `pend_dir` : `direction`) and B = `direction`; go to ADDR_A.
- ADDR_A: drive `map_x`/`map_y` with the next cell for A; go to READ_A.
- READ_A:
  - A is free if `map_wall`=0 and the next cell is inside the borders.
  - If free: commit (`xpos`/`ypos` = next cell, `direction`=A, `moving`=1, clear `pend_v` when A came from pending); go to IDLE.
  - Else, if A==B: `moving`=0, no position change; go to IDLE.
  - Else: go to ADDR_B.
- ADDR_B / READ_B: same probe for B.
  - Free: move along B, keep `pend_v`.
  - Blocked: `moving`=0.
  - Either way, go to IDLE.
- `step_done` pulses in the cycle after the READ state resolves.

**Arithmetic**
- Next cell is computed at 6 bits and compared against the borders before truncating to 5 bits.
- Out-of-border counts as blocked whatever `map_wall` says; the probe still takes its cycles.
- `joy_valid` during a probe updates the pending register only; the in-flight probe uses its snapshot.

## Timing

**Reset values** (`reset_n`=0 sampled on a clk edge)
- `xpos`=`START_X`, `ypos`=`START_Y`, `direction`=`START_DIR`.
- `moving`=0, `step_done`=0, `map_x`=`map_y`=0.
- Counter=0, `pend_v`=0, state IDLE.
- Reset mid-probe aborts the probe with no commit.

**Latency** (E0 = trigger edge)
- Primary path: outputs update at E2; `step_done` high E2→E3.
- Fallback path: outputs update at E4; `step_done` high E4→E5.
- All outputs are registered.
- `map_x`/`map_y` hold their last probe value while IDLE.

## Configuration

- `PACMAN_TUNNEL_EN` defined:
  - A left move at `BORDER_X_MIN` wraps to `BORDER_X_MAX`.
  - A right move at `BORDER_X_MAX` wraps to `BORDER_X_MIN`.
  - The wrapped cell is probed like any other cell.
- Undefined: these moves are blocked.
- Vertical borders always block in both builds.

## Test plan

- Reset: `reset_n`=0, then released, no input → `xpos`=2, `ypos`=2, `direction`=3. Open map, 8 `ce` ticks → `xpos`=3 at E2, `step_done` one cycle.
- Buffered turn: `joy_dir`=2 at (3,2), wall at (3,3) → fallback moves right to (4,2) at E4, `pend_v` stays 1. Next step with (4,3) open → `ypos`=3, `direction`=2, `pend_v`=0.
- Dead end: heading right, (x+1) wall, no pending → position unchanged, `moving`=0, `step_done` at E2.
- Border: `xpos`=28, `direction`=3, `map_wall`=0 → without the macro: blocked, `moving`=0. With `PACMAN_TUNNEL_EN`: `xpos`=1.
- Late input: `joy_valid` (dir 0) asserted at E1 → current step uses the old snapshot; dir 0 is applied on the following step.
- Mid-probe reset: `reset_n`=0 at E1 → no commit, outputs back to start values, `step_done` never pulses.
